// File: rtl/pkt_sfifo.sv
// pkt_sfifo: single-clock FIFO with packet commit / rollback on the write side.
//
// The writer stages words past the committed tail; i_commit publishes them to the
// reader and i_rollback discards them. The reader only sees committed words.
// A write lost to a full FIFO poisons the staged packet: the next commit is
// turned into a rollback and reported on o_dropped.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_wr, i_data       write strobe / data (staged)
//   i_commit           publish all staged words, including this cycle's write
//   i_rollback         discard all staged words, including this cycle's write
//   o_full             no free slot (staged + committed words)
//   o_dropped          one-cycle pulse: a commit was converted to a rollback
//   i_rd               read strobe (ignored while empty)
//   o_data             head committed word (asynchronous read)
//   o_empty            no committed word available
//   o_fill             committed word count
module pkt_sfifo #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_commit,
  input  logic              i_rollback,
  output logic              o_full,
  output logic              o_dropped,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill
);

  localparam int              FLEN     = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_CNT = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] PTR_ONE  = {{LGFLEN{1'b0}}, 1'b1};

  logic [BW-1:0]   mem [FLEN];

  // Pointers carry one extra bit so full (diff == FLEN) and empty (diff == 0)
  // stay distinguishable across wrap-around.
  logic [LGFLEN:0] wr_addr_q, wr_addr_d;
  logic [LGFLEN:0] cm_addr_q, cm_addr_d;
  logic [LGFLEN:0] rd_addr_q, rd_addr_d;
  logic            r_drop_q, r_drop_d;
  logic            dropped_q, dropped_d;

  logic            w_wr, w_rd, w_lost, drop_now;

  assign o_full    = (wr_addr_q - rd_addr_q) == FULL_CNT;
  assign o_empty   = (cm_addr_q == rd_addr_q);
  assign o_fill    = cm_addr_q - rd_addr_q;
  assign o_data    = mem[rd_addr_q[LGFLEN-1:0]];
  assign o_dropped = dropped_q;

  assign w_wr     = i_wr && !o_full && !i_rollback;
  assign w_lost   = i_wr &&  o_full && !i_rollback;
  assign w_rd     = i_rd && !o_empty;
  // A write lost this very cycle also poisons a same-cycle commit.
  assign drop_now = r_drop_q || w_lost;

  always_comb begin
    wr_addr_d = wr_addr_q;
    cm_addr_d = cm_addr_q;
    rd_addr_d = rd_addr_q;
    r_drop_d  = r_drop_q;
    dropped_d = 1'b0;

    if (w_wr)   wr_addr_d = wr_addr_q + PTR_ONE;
    if (w_lost) r_drop_d  = 1'b1;
    if (w_rd)   rd_addr_d = rd_addr_q + PTR_ONE;

    if (i_rollback) begin
      wr_addr_d = cm_addr_q;
      r_drop_d  = 1'b0;
    end else if (i_commit) begin
      r_drop_d = 1'b0;
      if (drop_now) begin
        wr_addr_d = cm_addr_q;
        dropped_d = 1'b1;
      end else begin
        // wr_addr_d already includes this cycle's accepted write.
        cm_addr_d = wr_addr_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) mem[wr_addr_q[LGFLEN-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_addr_q <= '0;
      cm_addr_q <= '0;
      rd_addr_q <= '0;
      r_drop_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      cm_addr_q <= cm_addr_d;
      rd_addr_q <= rd_addr_d;
      r_drop_q  <= r_drop_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_pkt_sfifo.sv
// Self-checking bench for pkt_sfifo. A packet-level reference model (committed
// and staged word queues plus a poisoned flag) predicts flags each cycle and
// pushes expected read data into a scoreboard; a negedge monitor pops and
// compares whenever the DUT performs a read.
module tb_pkt_sfifo;
  localparam int BW     = 8;
  localparam int LGFLEN = 4;
  localparam int FLEN   = 1 << LGFLEN;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_wr = 1'b0;
  logic [BW-1:0]     i_data = '0;
  logic              i_commit = 1'b0;
  logic              i_rollback = 1'b0;
  logic              i_rd = 1'b0;
  logic              o_full, o_dropped, o_empty;
  logic [BW-1:0]     o_data;
  logic [LGFLEN:0]   o_fill;

  always #5 i_clk = ~i_clk;

  pkt_sfifo #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wr(i_wr), .i_data(i_data), .i_commit(i_commit), .i_rollback(i_rollback),
    .o_full(o_full), .o_dropped(o_dropped),
    .i_rd(i_rd), .o_data(o_data), .o_empty(o_empty), .o_fill(o_fill)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [BW-1:0] cq[$];     // committed words, head first
  logic [BW-1:0] sq[$];     // staged words
  bit            m_drop;    // staged packet lost a word
  bit            m_dropped; // expected o_dropped for the current cycle
  logic [BW-1:0] exp_q[$];  // scoreboard of expected read data

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle. Flags from the previous edge are checked first, then the
  // new inputs are applied and the model advanced to the state after the edge.
  task automatic cycle(input bit wr, input logic [BW-1:0] d, input bit cm,
                       input bit rb, input bit rd, input bit rst);
    bit full, empty, lost;
    @(posedge i_clk); #1;
    chk("o_full",    o_full,    32'((cq.size() + sq.size()) == FLEN));
    chk("o_empty",   o_empty,   32'(cq.size() == 0));
    chk("o_fill",    o_fill,    32'(cq.size()));
    chk("o_dropped", o_dropped, 32'(m_dropped));

    i_reset = rst; i_wr = wr; i_data = d; i_commit = cm; i_rollback = rb; i_rd = rd;

    if (rst) begin
      cq.delete(); sq.delete(); m_drop = 0; m_dropped = 0;
      return;
    end
    full  = (cq.size() + sq.size()) == FLEN;
    empty = (cq.size() == 0);
    lost  = wr && full && !rb;
    if (rd && !empty) exp_q.push_back(cq.pop_front());
    if (wr && !full && !rb) sq.push_back(d);
    m_dropped = 0;
    if (rb) begin
      sq.delete(); m_drop = 0;
    end else if (cm) begin
      if (m_drop || lost) m_dropped = 1;
      else foreach (sq[k]) cq.push_back(sq[k]);
      sq.delete(); m_drop = 0;
    end else if (lost) begin
      m_drop = 1;
    end
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0, 0);
  endtask

  task automatic rd1();
    cycle(0, '0, 0, 0, 1, 0);
  endtask

  // Monitor: compare read data whenever the DUT accepts a read.
  always @(negedge i_clk) begin
    if (!i_reset && i_rd && !o_empty) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_read: got %0h expected no read at %0t", o_data, $time);
      end else begin
        chk("o_data", o_data, 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int rd_pct;
    cq.delete(); sq.delete(); m_drop = 0; m_dropped = 0;

    // Reset state, then basic packet of three words.
    cycle(0, '0, 0, 0, 0, 1);
    idle();
    cycle(1, 8'h11, 0, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0, 0);
    cycle(1, 8'h33, 1, 0, 0, 0);
    idle();
    rd1(); rd1(); rd1();
    idle();

    // Rollback, then a single committed word.
    cycle(1, 8'hA1, 0, 0, 0, 0);
    cycle(1, 8'hA2, 0, 0, 0, 0);
    cycle(0, '0, 0, 1, 0, 0);
    idle();
    cycle(1, 8'hC1, 1, 0, 0, 0);
    idle();
    rd1();
    idle();

    // Oversized packet: 17 words, commit on the last -> dropped.
    for (int i = 0; i <= 16; i++) cycle(1, 8'(i), (i == 16), 0, 0, 0);
    idle(); idle();

    // Full committed FIFO; write while reading is dropped, then a slot opens.
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h40 + i), (i == 15), 0, 0, 0);
    idle();
    cycle(1, 8'hEE, 0, 0, 1, 0);
    idle();
    cycle(1, 8'hEF, 0, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);   // commit after a lost word -> dropped
    idle();
    for (int i = 0; i < 15; i++) rd1();
    idle();

    // Commit and rollback together: rollback wins.
    cycle(1, 8'h71, 0, 0, 0, 0);
    cycle(1, 8'h72, 0, 0, 0, 0);
    cycle(0, '0, 1, 1, 0, 0);
    idle(); idle();

    // Reset mid-packet discards staged and committed data.
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h90 + i), (i == 3), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'hB0 + i), 0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1);
    idle();
    cycle(1, 8'h55, 1, 0, 0, 0);
    idle();
    rd1();
    idle();

    // Randomized traffic with phases of varying read pressure.
    for (int i = 0; i < 4000; i++) begin
      case ((i / 300) % 4)
        0: rd_pct = 50;
        1: rd_pct = 10;
        2: rd_pct = 90;
        default: rd_pct = 30;
      endcase
      cycle($urandom_range(99) < 70, 8'($urandom), $urandom_range(7) == 0,
            $urandom_range(29) == 0, $urandom_range(99) < rd_pct,
            $urandom_range(499) == 0);
    end
    idle(); idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
